// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter.
//   state_e : arbiter FSM states
//   owner_e : which requester owns the port (fetch or data)
//   CNT_W   : width of the read-latency down-counter (MEM_LAT up to 15)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-way grant selection between the fetch and data requesters.
// Purely combinational.
//   if_req, d_req : pending requests
//   last_served   : owner of the last completed transaction (0 = fetch, 1 = data)
//   grant_valid   : at least one request is pending
//   grant_owner   : winner (0 = fetch, 1 = data)
// On a tie, DATA_PRIO != 0 always picks data; otherwise the requester not
// served last wins.
module mem_arb_rr2
  import mem_arb_pkg::*;
#(
  parameter int DATA_PRIO = 0
) (
  input  logic if_req,
  input  logic d_req,
  input  logic last_served,
  output logic grant_valid,
  output logic grant_owner
);

  always_comb begin
    grant_valid = if_req | d_req;
    grant_owner = OWN_IF;
    if (if_req && d_req) begin
      grant_owner = ((DATA_PRIO != 0) || (last_served == OWN_IF)) ? OWN_D : OWN_IF;
    end else if (d_req) begin
      grant_owner = OWN_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory port between the instruction-fetch and the
// load/store requesters. Serialises the two, sequences the memory's fixed
// read latency and returns a one-cycle ack with registered read data.
//   CLK, RST                 : clock, async active-high reset
//   if_req/if_addr           : fetch request (held until if_ack)
//   if_ack/if_rdata          : fetch completion and data
//   d_req/d_we/d_addr/d_wdata: data request (held until d_ack)
//   d_ack/d_rdata            : data completion and load data
//   mem_addr/mem_wdata/mem_wr: registered memory port, write strobe
//   mem_rdata                : memory read data, valid MEM_LAT cycles after addr
//   busy                     : FSM not in IDLE
//   owner                    : owner of current/last transaction (0 fetch, 1 data)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int MEM_LAT   = 1,
  parameter int DATA_PRIO = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  state_e           state, state_nxt;
  owner_e           own_r, last_served;
  logic             we_r;
  logic [CNT_W-1:0] cnt;
  logic             grant_valid, grant_owner;

  mem_arb_rr2 #(.DATA_PRIO(DATA_PRIO)) u_rr (
    .if_req      (if_req),
    .d_req       (d_req),
    .last_served (last_served),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Acks and mem_wr decode straight from state so reset drops them at once.
  always_comb begin
    state_nxt = state;
    mem_wr    = 1'b0;
    if_ack    = 1'b0;
    d_ack     = 1'b0;
    case (state)
      IDLE:   if (grant_valid) state_nxt = ACCESS;
      ACCESS: begin
        mem_wr = we_r;
        // Writes complete in one cycle; reads wait for the counter.
        if (we_r || cnt == '0) state_nxt = RESP;
      end
      RESP: begin
        if_ack    = (own_r == OWN_IF);
        d_ack     = (own_r == OWN_D);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy  = (state != IDLE);
  assign owner = own_r;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mem_addr    <= '0;
      mem_wdata   <= '0;
      we_r        <= 1'b0;
      own_r       <= OWN_IF;
      last_served <= OWN_IF;
      cnt         <= '0;
      if_rdata    <= '0;
      d_rdata     <= '0;
    end else begin
      case (state)
        IDLE: if (grant_valid) begin
          own_r <= owner_e'(grant_owner);
          cnt   <= CNT_W'(MEM_LAT - 1);
          if (grant_owner == OWN_D) begin
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            we_r      <= d_we;
          end else begin
            // Fetch port has no write path; mem_wdata keeps its old value.
            mem_addr <= if_addr;
            we_r     <= 1'b0;
          end
        end
        ACCESS: if (!we_r) begin
          if (cnt == '0) begin
            if (own_r == OWN_D) d_rdata  <= mem_rdata;
            else                if_rdata <= mem_rdata;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: last_served <= own_r;
        default: ;
      endcase
    end
  end

  a_lat_legal:   assert property (@(posedge CLK) (MEM_LAT >= 1) && (MEM_LAT <= 15));
  a_no_if_store: assert property (@(posedge CLK) disable iff (RST) !(own_r == OWN_IF && we_r));
  a_one_ack:     assert property (@(posedge CLK) disable iff (RST) !(if_ack && d_ack));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter. Two instances:
//   gi[0]: MEM_LAT=3, DATA_PRIO=0   gi[1]: MEM_LAT=1, DATA_PRIO=1
// Expected transactions are queued as stimulus is driven; a negedge monitor
// pops and checks them whenever an ack appears.
module tb_mem_port_arbiter;

  typedef struct {
    int          inst;
    logic        own;
    logic        we;
    logic [63:0] addr;
    logic [63:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0]       if_req, if_ack, d_req, d_we, d_ack, mem_wr, busy, owner;
  logic [1:0][63:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
  logic [1:0][63:0] mem_addr, mem_wdata, mem_rdata;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   t_smp = 0;
  int   wr_cnt [2];
  logic [63:0] trk_if [2];
  logic [63:0] trk_d  [2];
  exp_t sbq [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] memval(input logic [63:0] a);
    if (a == 64'h40) return 64'h13;
    return {a[31:0] ^ 32'h5A5A_5A5A, ~a[31:0]};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gi
    logic [63:0] mem [256];
    mem_port_arbiter #(
      .ADDR_W(64), .DATA_W(64), .MEM_LAT(g == 0 ? 3 : 1), .DATA_PRIO(g)
    ) u_dut (
      .CLK(clk), .RST(rst),
      .if_req(if_req[g]), .if_addr(if_addr[g]), .if_ack(if_ack[g]), .if_rdata(if_rdata[g]),
      .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
      .d_ack(d_ack[g]), .d_rdata(d_rdata[g]),
      .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]), .mem_wr(mem_wr[g]),
      .mem_rdata(mem_rdata[g]), .busy(busy[g]), .owner(owner[g])
    );
    always @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < 256; i++) mem[i] <= memval(64'(i) << 3);
      end else if (mem_wr[g]) begin
        mem[mem_addr[g][10:3]] <= mem_wdata[g];
      end
    end
    assign mem_rdata[g] = mem[mem_addr[g][10:3]];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input int g, input logic own, input logic we,
                      input logic [63:0] addr, input logic [63:0] data);
    exp_t e;
    e.inst = g; e.own = own; e.we = we; e.addr = addr; e.data = data;
    e.cyc  = t_smp + (we ? 1 : (g == 0 ? 3 : 1));
    t_smp  = e.cyc + 2;
    sbq.push_back(e);
  endtask

  task automatic chk_ack(input int g);
    exp_t e;
    check("sb_nonempty", 64'(sbq.size() > 0), 64'd1);
    if (sbq.size() == 0) return;
    e = sbq.pop_front();
    check("ack_inst",     64'(g), 64'(e.inst));
    check("ack_owner",    64'(d_ack[g]), 64'(e.own));
    check("owner_out",    64'(owner[g]), 64'(e.own));
    check("ack_both",     64'(if_ack[g] & d_ack[g]), 64'd0);
    check("ack_cycle",    64'(cyc), 64'(e.cyc));
    check("ack_mem_addr", mem_addr[g], e.addr);
    check("ack_wr_count", 64'(wr_cnt[g]), e.we ? 64'd1 : 64'd0);
    if (!e.we && e.own) begin
      check("d_rdata", d_rdata[g], e.data);
      trk_d[g] = e.data;
    end else if (!e.we) begin
      check("if_rdata", if_rdata[g], e.data);
      trk_if[g] = e.data;
    end
    check("if_rdata_hold", if_rdata[g], trk_if[g]);
    check("d_rdata_hold",  d_rdata[g],  trk_d[g]);
    wr_cnt[g] = 0;
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rst) begin
        trk_if[g] = '0; trk_d[g] = '0; wr_cnt[g] = 0;
      end else begin
        if (mem_wr[g]) begin
          exp_t e;
          e = '{default: 0};
          if (sbq.size() > 0) e = sbq[0];
          check("mem_wr_we",    64'(e.we), 64'd1);
          check("mem_wr_addr",  mem_addr[g], e.addr);
          check("mem_wr_wdata", mem_wdata[g], e.data);
          wr_cnt[g]++;
        end
        if (if_ack[g] || d_ack[g]) chk_ack(g);
      end
    end
  end

  task automatic wait_acks(input int g, input int n);
    int seen = 0;
    for (int k = 0; k < 200 && seen < n; k++) begin
      @(negedge clk);
      if (if_ack[g] || d_ack[g]) seen++;
    end
    check("ack_seen", 64'(seen), 64'(n));
  endtask

  task automatic start();
    @(negedge clk);
    t_smp = cyc + 1;
  endtask

  initial begin
    if_req = '0; d_req = '0; d_we = '0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check("rst_busy",      64'(busy[g]),   64'd0);
      check("rst_owner",     64'(owner[g]),  64'd0);
      check("rst_if_ack",    64'(if_ack[g]), 64'd0);
      check("rst_d_ack",     64'(d_ack[g]),  64'd0);
      check("rst_mem_wr",    64'(mem_wr[g]), 64'd0);
      check("rst_mem_addr",  mem_addr[g],    64'd0);
      check("rst_mem_wdata", mem_wdata[g],   64'd0);
      check("rst_if_rdata",  if_rdata[g],    64'd0);
      check("rst_d_rdata",   d_rdata[g],     64'd0);
    end
    rst = 1'b0;

    // Single fetch, MEM_LAT=1.
    start();
    if_addr[1] = 64'h40; if_req[1] = 1'b1;
    push(1, 1'b0, 1'b0, 64'h40, 64'h13);
    wait_acks(1, 1);
    if_req[1] = 1'b0;

    // Back-to-back fetches with if_req held, address moving on each ack.
    start();
    if_addr[1] = 64'h80; if_req[1] = 1'b1;
    for (int k = 0; k < 4; k++) push(1, 1'b0, 1'b0, 64'h80 + 64'(8 * k), memval(64'h80 + 64'(8 * k)));
    for (int k = 0; k < 4; k++) begin
      wait_acks(1, 1);
      if (k == 3) if_req[1] = 1'b0;
      else        if_addr[1] = 64'h80 + 64'(8 * (k + 1));
    end

    // DATA_PRIO=1 tie: three data loads win before the fetch.
    start();
    d_addr[1] = 64'h200; d_we[1] = 1'b0; d_req[1] = 1'b1;
    if_addr[1] = 64'h218; if_req[1] = 1'b1;
    for (int k = 0; k < 3; k++) push(1, 1'b1, 1'b0, 64'h200 + 64'(8 * k), memval(64'h200 + 64'(8 * k)));
    push(1, 1'b0, 1'b0, 64'h218, memval(64'h218));
    for (int k = 0; k < 3; k++) begin
      wait_acks(1, 1);
      if (k == 2) d_req[1] = 1'b0;
      else        d_addr[1] = d_addr[1] + 64'd8;
    end
    wait_acks(1, 1);
    if_req[1] = 1'b0;

    // DATA_PRIO=0 tie from reset: D, IF, D, IF.
    start();
    d_addr[0] = 64'h300; d_we[0] = 1'b0; d_req[0] = 1'b1;
    if_addr[0] = 64'h400; if_req[0] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      push(0, 1'b1, 1'b0, 64'h300, memval(64'h300));
      push(0, 1'b0, 1'b0, 64'h400, memval(64'h400));
    end
    wait_acks(0, 4);
    d_req[0] = 1'b0; if_req[0] = 1'b0;

    // Store then load of the same address, MEM_LAT=3.
    start();
    d_addr[0] = 64'h100; d_wdata[0] = 64'hDEAD_BEEF_CAFE_F00D; d_we[0] = 1'b1; d_req[0] = 1'b1;
    push(0, 1'b1, 1'b1, 64'h100, 64'hDEAD_BEEF_CAFE_F00D);
    wait_acks(0, 1);
    d_req[0] = 1'b0;
    start();
    d_we[0] = 1'b0; d_wdata[0] = '0; d_req[0] = 1'b1;
    push(0, 1'b1, 1'b0, 64'h100, 64'hDEAD_BEEF_CAFE_F00D);
    wait_acks(0, 1);
    d_req[0] = 1'b0;

    // Async reset in the 2nd ACCESS cycle of a read; last-served returns to fetch.
    start();
    d_addr[0] = 64'h500; d_we[0] = 1'b0; d_req[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_busy", 64'(busy[0]), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("abort_busy",   64'(busy[0]),   64'd0);
    check("abort_d_ack",  64'(d_ack[0]),  64'd0);
    check("abort_if_ack", 64'(if_ack[0]), 64'd0);
    check("abort_mem_wr", 64'(mem_wr[0]), 64'd0);
    check("abort_d_rdata", d_rdata[0],    64'd0);
    if_addr[0] = 64'h600; if_req[0] = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    t_smp = cyc + 1;
    push(0, 1'b1, 1'b0, 64'h500, memval(64'h500));
    push(0, 1'b0, 1'b0, 64'h600, memval(64'h600));
    wait_acks(0, 1);
    d_req[0] = 1'b0;
    wait_acks(0, 1);
    if_req[0] = 1'b0;

    repeat (4) @(negedge clk);
    check("sb_drained", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
